// File: rtl/image_mem_arbiter.sv
// Shares one single-port image RAM between the VGA scan reader (priority) and the median-filter
// window engine, with bounded filter bursts and starvation protection for the filter.
//
// state       | meaning
// ------------+-------------------------------------------------------------------
// ST_ARB      | normal arbitration: VGA first unless the filter has waited MAX_WAIT
// ST_BURST    | filter holds the port while FLT_REQ & FLT_LOCK, up to MAX_BURST grants
// ST_BACKOFF  | one cycle after a full burst: VGA first, filter only if VGA idle
module image_mem_arbiter #(
   parameter int D_WIDTH   = 8,
   parameter int A_WIDTH   = 16,
   parameter int MAX_WAIT  = 15,
   parameter int MAX_BURST = 9
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               VGA_REQ,
   input  logic [A_WIDTH-1:0] VGA_ADDR,
   output logic               VGA_GNT,
   output logic               VGA_VALID,
   output logic [D_WIDTH-1:0] VGA_DATA,
   input  logic               FLT_REQ,
   input  logic               FLT_WE,
   input  logic               FLT_LOCK,
   input  logic [A_WIDTH-1:0] FLT_ADDR,
   input  logic [D_WIDTH-1:0] FLT_WDATA,
   output logic               FLT_GNT,
   output logic               FLT_VALID,
   output logic [D_WIDTH-1:0] FLT_RDATA,
   output logic [A_WIDTH-1:0] MEM_ADDR,
   output logic               MEM_WREN,
   output logic [D_WIDTH-1:0] MEM_WDATA,
   input  logic [D_WIDTH-1:0] MEM_Q,
   output logic               VGA_MISS
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int BW = $clog2(MAX_BURST + 1);

   localparam logic [1:0] ST_ARB     = 2'd0;
   localparam logic [1:0] ST_BURST   = 2'd1;
   localparam logic [1:0] ST_BACKOFF = 2'd2;

   localparam logic [1:0] RD_NONE = 2'd0;
   localparam logic [1:0] RD_VGA  = 2'd1;
   localparam logic [1:0] RD_FLT  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [WW-1:0]      wait_rem_q, wait_rem_d;
   logic [BW-1:0]      burst_rem_q, burst_rem_d;
   logic [1:0]         rd_owner_q, rd_owner_d;
   logic [A_WIDTH-1:0] addr_q, addr_d;
   logic [D_WIDTH-1:0] vga_data_q, vga_data_d;
   logic [D_WIDTH-1:0] flt_data_q, flt_data_d;
   logic               miss_q, miss_d;
   logic               vga_gnt, flt_gnt;
   logic [1:0]         arb_mode;

   always_comb begin
      state_d     = state_q;
      wait_rem_d  = wait_rem_q;
      burst_rem_d = burst_rem_q;
      vga_gnt     = 1'b0;
      flt_gnt     = 1'b0;
      arb_mode    = state_q;

      // A burst that loses its lock or request is arbitrated as a plain ARB cycle
      if (state_q == ST_BURST && !(FLT_REQ && FLT_LOCK))
         arb_mode = ST_ARB;

      case (arb_mode)
         ST_ARB: begin
            if (VGA_REQ) begin
               if (FLT_REQ && wait_rem_q == '0)
                  flt_gnt = 1'b1;
               else
                  vga_gnt = 1'b1;
            end else begin
               flt_gnt = FLT_REQ;
            end
         end
         ST_BURST:   flt_gnt = 1'b1;
         ST_BACKOFF: begin
            if (VGA_REQ)
               vga_gnt = 1'b1;
            else
               flt_gnt = FLT_REQ;
         end
         default: ;
      endcase

      if (!nRST) begin
         vga_gnt = 1'b0;
         flt_gnt = 1'b0;
      end

      case (arb_mode)
         ST_ARB: begin
            state_d = ST_ARB;
            if (flt_gnt && FLT_LOCK) begin
               if (MAX_BURST == 1) begin
                  state_d = ST_BACKOFF;
               end else begin
                  state_d     = ST_BURST;
                  burst_rem_d = BW'(MAX_BURST - 1);
               end
            end
         end
         ST_BURST: begin
            burst_rem_d = burst_rem_q - BW'(1);
            if (burst_rem_q == BW'(1))
               state_d = ST_BACKOFF;
         end
         default: state_d = ST_ARB;
      endcase

      // Down-counter of refusals left before the filter is forced in
      if (FLT_REQ && !flt_gnt) begin
         if (wait_rem_q != '0)
            wait_rem_d = wait_rem_q - WW'(1);
      end else begin
         wait_rem_d = WW'(MAX_WAIT);
      end
   end

   always_comb begin
      addr_d = addr_q;
      if (vga_gnt)
         addr_d = VGA_ADDR;
      else if (flt_gnt)
         addr_d = FLT_ADDR;

      rd_owner_d = RD_NONE;
      if (vga_gnt)
         rd_owner_d = RD_VGA;
      else if (flt_gnt && !FLT_WE)
         rd_owner_d = RD_FLT;

      // Read data is passed straight through in the valid cycle and held afterwards
      vga_data_d = (rd_owner_q == RD_VGA) ? MEM_Q : vga_data_q;
      flt_data_d = (rd_owner_q == RD_FLT) ? MEM_Q : flt_data_q;
      miss_d     = VGA_REQ && !vga_gnt;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= ST_ARB;
         wait_rem_q  <= WW'(MAX_WAIT);
         burst_rem_q <= '0;
         rd_owner_q  <= RD_NONE;
         addr_q      <= '0;
         vga_data_q  <= '0;
         flt_data_q  <= '0;
         miss_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_rem_q  <= wait_rem_d;
         burst_rem_q <= burst_rem_d;
         rd_owner_q  <= rd_owner_d;
         addr_q      <= addr_d;
         vga_data_q  <= vga_data_d;
         flt_data_q  <= flt_data_d;
         miss_q      <= miss_d;
      end
   end

   assign VGA_GNT   = vga_gnt;
   assign FLT_GNT   = flt_gnt;
   assign MEM_ADDR  = addr_d;
   assign MEM_WREN  = flt_gnt && FLT_WE;
   assign MEM_WDATA = FLT_WDATA;
   assign VGA_VALID = (rd_owner_q == RD_VGA);
   assign FLT_VALID = (rd_owner_q == RD_FLT);
   assign VGA_DATA  = vga_data_d;
   assign FLT_RDATA = flt_data_d;
   assign VGA_MISS  = miss_q;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Bench for image_mem_arbiter: directed scenarios then random traffic, every cycle compared
// against a cycle-level model of the arbitration rules and a shadow copy of the RAM.
module tb_image_mem_arbiter;

   localparam int MAX_WAIT  = 15;
   localparam int MAX_BURST = 9;
   localparam int M_ARB = 0, M_BURST = 1, M_BACK = 2;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        VGA_REQ, FLT_REQ, FLT_WE, FLT_LOCK;
   logic [15:0] VGA_ADDR, FLT_ADDR, MEM_ADDR;
   logic [7:0]  FLT_WDATA, VGA_DATA, FLT_RDATA, MEM_WDATA, MEM_Q;
   logic        VGA_GNT, VGA_VALID, FLT_GNT, FLT_VALID, MEM_WREN, VGA_MISS;

   logic        pre_we;
   logic [15:0] pre_addr;
   logic [7:0]  pre_data;
   logic [7:0]  ram     [0:65535];
   logic [7:0]  ref_mem [0:65535];

   int n_checks = 0, n_pass = 0;
   int m_mode, m_wait, m_burst;
   logic        e_vv, e_fv, e_miss;
   logic [7:0]  e_vd, e_fd;
   logic [15:0] e_addr;
   int flt_gnt_seen, wren_seen, fvalid_seen;
   logic obs_vga_gnt;

   image_mem_arbiter dut (
      .CLK(CLK), .nRST(nRST),
      .VGA_REQ(VGA_REQ), .VGA_ADDR(VGA_ADDR), .VGA_GNT(VGA_GNT), .VGA_VALID(VGA_VALID),
      .VGA_DATA(VGA_DATA),
      .FLT_REQ(FLT_REQ), .FLT_WE(FLT_WE), .FLT_LOCK(FLT_LOCK), .FLT_ADDR(FLT_ADDR),
      .FLT_WDATA(FLT_WDATA), .FLT_GNT(FLT_GNT), .FLT_VALID(FLT_VALID), .FLT_RDATA(FLT_RDATA),
      .MEM_ADDR(MEM_ADDR), .MEM_WREN(MEM_WREN), .MEM_WDATA(MEM_WDATA), .MEM_Q(MEM_Q),
      .VGA_MISS(VGA_MISS)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (pre_we)
         ram[pre_addr] <= pre_data;
      else if (MEM_WREN)
         ram[MEM_ADDR] <= MEM_WDATA;
      MEM_Q <= ram[MEM_ADDR];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: check at the falling edge, advance the model at the rising edge
   task automatic step();
      logic gv, gf, vr, fr, fl, fw;
      logic [15:0] va, fa, exp_addr;
      logic [7:0]  fd;
      int eff;
      @(negedge CLK);
      vr = VGA_REQ; fr = FLT_REQ; fl = FLT_LOCK; fw = FLT_WE;
      va = VGA_ADDR; fa = FLT_ADDR; fd = FLT_WDATA;
      if (!nRST) begin
         m_mode = M_ARB; m_wait = 0; m_burst = 0;
         e_vv = 0; e_fv = 0; e_miss = 0; e_vd = 0; e_fd = 0; e_addr = 0;
      end
      gv = 0; gf = 0; eff = m_mode;
      if (nRST) begin
         if (m_mode == M_BURST && !(fr && fl)) eff = M_ARB;
         if (eff == M_BURST) gf = 1;
         else if (eff == M_BACK) begin
            if (vr) gv = 1; else gf = fr;
         end else begin
            if (vr && fr && m_wait == MAX_WAIT) gf = 1;
            else if (vr) gv = 1;
            else gf = fr;
         end
      end
      exp_addr = gv ? va : (gf ? fa : e_addr);
      chk("vga_gnt", VGA_GNT, gv);
      chk("flt_gnt", FLT_GNT, gf);
      chk("mem_addr", MEM_ADDR, exp_addr);
      chk("mem_wren", MEM_WREN, gf && fw);
      if (gf && fw) chk("mem_wdata", MEM_WDATA, fd);
      chk("vga_valid", VGA_VALID, e_vv);
      chk("flt_valid", FLT_VALID, e_fv);
      chk("vga_data", VGA_DATA, e_vd);
      chk("flt_rdata", FLT_RDATA, e_fd);
      chk("vga_miss", VGA_MISS, e_miss);
      if (FLT_GNT) flt_gnt_seen++;
      if (MEM_WREN) wren_seen++;
      if (FLT_VALID) fvalid_seen++;
      obs_vga_gnt = VGA_GNT;
      @(posedge CLK);
      if (nRST) begin
         e_addr = exp_addr;
         e_vv   = gv;
         e_fv   = gf && !fw;
         e_miss = vr && !gv;
         if (gv) e_vd = ref_mem[va];
         if (gf && !fw) e_fd = ref_mem[fa];
         if (gf && fw) ref_mem[fa] = fd;
         if (eff == M_ARB) begin
            if (gf && fl) begin
               m_burst = 1;
               m_mode = (m_burst == MAX_BURST) ? M_BACK : M_BURST;
            end else m_mode = M_ARB;
         end else if (eff == M_BURST) begin
            m_burst++;
            m_mode = (m_burst == MAX_BURST) ? M_BACK : M_BURST;
         end else m_mode = M_ARB;
         if (fr && !gf) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
         else m_wait = 0;
      end
      #1;
   endtask

   function automatic logic [15:0] win_addr();
      return 16'h0100 + 16'($urandom_range(0, 15));
   endfunction

   initial begin
      nRST = 0; VGA_REQ = 1; FLT_REQ = 1; FLT_WE = 0; FLT_LOCK = 0;
      VGA_ADDR = 0; FLT_ADDR = 0; FLT_WDATA = 0;
      pre_we = 0; pre_addr = 0; pre_data = 0;
      m_mode = M_ARB; m_wait = 0; m_burst = 0;
      e_vv = 0; e_fv = 0; e_miss = 0; e_vd = 0; e_fd = 0; e_addr = 0;
      flt_gnt_seen = 0; wren_seen = 0; fvalid_seen = 0; obs_vga_gnt = 0;
      @(posedge CLK); #1;

      // Reset held with both requests high, RAM window preloaded meanwhile
      for (int i = 0; i < 17; i++) begin
         pre_we   = 1;
         pre_addr = (i == 16) ? 16'h1234 : 16'h0100 + 16'(i);
         pre_data = (i == 16) ? 8'hA5 : 8'($urandom);
         ref_mem[pre_addr] = pre_data;
         step();
      end
      pre_we = 0;

      // Release: VGA read of 0x1234
      nRST = 1; FLT_REQ = 0; VGA_ADDR = 16'h1234;
      step();
      chk("t1_vga_gnt_after_rst", obs_vga_gnt, 1'b1);
      VGA_REQ = 0;
      step();

      // Both requesters saturating: filter forced in every 16th cycle
      VGA_REQ = 1; FLT_REQ = 1; FLT_LOCK = 0; FLT_WE = 0;
      flt_gnt_seen = 0;
      for (int i = 0; i < 48; i++) begin
         VGA_ADDR = win_addr(); FLT_ADDR = win_addr();
         step();
      end
      chk("t3_forced_grants", flt_gnt_seen, 3);

      // Locked filter burst, VGA arrives mid-burst
      VGA_REQ = 0; FLT_LOCK = 1;
      flt_gnt_seen = 0;
      for (int i = 0; i < 9; i++) begin
         if (i == 3) VGA_REQ = 1;
         FLT_ADDR = win_addr();
         step();
      end
      chk("t4_burst_len", flt_gnt_seen, 9);
      step();
      chk("t4_backoff_vga", obs_vga_gnt, 1'b1);
      step();
      chk("t4_arb_vga_keeps", obs_vga_gnt, 1'b1);
      VGA_REQ = 0;
      step();
      step();
      FLT_REQ = 0; FLT_LOCK = 0;
      step();

      // Filter write then read-back of 0x0101
      wren_seen = 0; fvalid_seen = 0;
      FLT_REQ = 1; FLT_WE = 1; FLT_ADDR = 16'h0101; FLT_WDATA = 8'h3C;
      step();
      FLT_WE = 0;
      step();
      FLT_REQ = 0;
      step();
      chk("t5_rdata", FLT_RDATA, 8'h3C);
      step();
      chk("t5_wren_count", wren_seen, 1);
      chk("t5_valid_count", fvalid_seen, 1);

      // Reset during a locked read burst
      FLT_REQ = 1; FLT_LOCK = 1; FLT_WE = 0;
      for (int i = 0; i < 3; i++) begin
         FLT_ADDR = win_addr();
         step();
      end
      nRST = 0;
      step();
      step();
      nRST = 1; VGA_REQ = 1; VGA_ADDR = win_addr();
      step();
      chk("t6_arb_after_rst", obs_vga_gnt, 1'b1);
      VGA_REQ = 0; FLT_REQ = 0; FLT_LOCK = 0;
      step();

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         VGA_REQ   = ($urandom_range(0, 3) != 0);
         FLT_REQ   = ($urandom_range(0, 2) != 0);
         FLT_LOCK  = ($urandom_range(0, 3) != 0);
         FLT_WE    = ($urandom_range(0, 3) == 0);
         VGA_ADDR  = win_addr();
         FLT_ADDR  = win_addr();
         FLT_WDATA = 8'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
